// File: rtl/video_proc_pkg.sv
// video_proc_pkg: shared constants, write FSM states and the saturation helper for video_proc_pipe_p
package video_proc_pkg;
  localparam int BRT_UNITY = 64;
  localparam int BRT_SHIFT = 6;
  typedef enum logic {IDLE, REQ} vp_wr_state_e;
  // Clamp to 2**dw-1 when any bit at or above dw is set; caller keeps the low dw bits.
  function automatic logic [31:0] vp_sat(input logic [63:0] wide, input int dw);
    return ((wide >> dw) != 64'd0) ? 32'((64'd1 << dw) - 64'd1) : wide[31:0];
  endfunction
endpackage

// File: rtl/vp_sync_fifo.sv
// vp_sync_fifo: first-word-fall-through FIFO exposing the two oldest entries, sticky overflow flag
module vp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         head2,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic do_push, do_pop;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign head = mem[rd];
  assign head2 = mem[rd + PW'(1)];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      if (do_push) wr <= wr + PW'(1);
      if (do_pop) rd <= rd + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      if (push & full) ovf <= 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/video_proc_pipe_p.sv
// video_proc_pipe_p: gain/saturate, optional check pattern (VP_CHECK_EN), FIFO, REQ/ACK frame-memory writer
module video_proc_pipe_p
  import video_proc_pkg::*;
#(
  parameter int NCH    = 3,
  parameter int DW     = 16,
  parameter int BW     = 7,
  parameter int DEPTH  = 8,
  parameter int AW     = 19,
  parameter int FWORDS = 131072
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [NCH*DW-1:0] in_pix,
  input  logic [BW-1:0]     brightness,
  input  logic              check,
  input  logic [DW-1:0]     chk_word,
  input  logic              frame_alt_frz,
  input  logic              fm_cycle_en,
  output logic              fm_wr_req,
  input  logic              fm_wr_ack,
  output logic [AW-1:0]     fm_wr_adrs,
  output logic [NCH*DW-1:0] fm_wr_d,
  output logic              fifo_ovf
);
  localparam int PWW = DW + BW;
  localparam int OW = AW - 1;
  localparam int FW = NCH*DW + 1;
  localparam int CW = $clog2(DEPTH) + 1;
  logic rdy_en, accept, v1, sof1, chk1, v2, sof2;
  logic [NCH*PWW-1:0] p1;
  logic [NCH*DW-1:0] s_nxt, s2;
  logic [31:0] sat;
  logic [FW-1:0] head, head2, load_word;
  logic empty, fifo_full_unused, pop, load, lbank, bank;
  logic [CW-1:0] cnt;
  logic [OW-1:0] nxt_off, inc, base, cur_off;
  vp_wr_state_e state, state_nxt;
  assign accept = in_valid & in_ready;
  // Count words still in the gain pipeline so nothing can arrive at a full FIFO.
  assign in_ready = rdy_en & ((cnt + CW'(v1) + CW'(v2)) < CW'(DEPTH));
  assign cur_off = fm_wr_adrs[OW-1:0];
  assign inc = (cur_off == OW'(FWORDS-1)) ? OW'(0) : cur_off + OW'(1);
  assign fm_wr_req = state == REQ;
  always_comb begin
    s_nxt = '0;
    sat = '0;
    for (int c = 0; c < NCH; c++) begin
      sat = vp_sat(64'(p1[c*PWW +: PWW] >> BRT_SHIFT), DW);
      s_nxt[c*DW +: DW] = sat[DW-1:0];
    end
`ifdef VP_CHECK_EN
    if (chk1) s_nxt = {NCH{chk_word}};
`endif
  end
`ifndef VP_CHECK_EN
  logic unused_chk;
  assign unused_chk = &{1'b0, chk1, chk_word};
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdy_en <= 1'b0;
      v1 <= 1'b0;
      sof1 <= 1'b0;
      chk1 <= 1'b0;
      p1 <= '0;
      v2 <= 1'b0;
      sof2 <= 1'b0;
      s2 <= '0;
    end else begin
      rdy_en <= 1'b1;
      v1 <= accept;
      v2 <= v1;
      if (accept) begin
        sof1 <= in_sof;
        chk1 <= check;
        for (int c = 0; c < NCH; c++)
          p1[c*PWW +: PWW] <= PWW'(in_pix[c*DW +: DW]) * PWW'(brightness);
      end
      if (v1) begin
        sof2 <= sof1;
        s2 <= s_nxt;
      end
    end
  vp_sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (v2),
    .pop   (pop),
    .din   ({sof2, s2}),
    .head  (head),
    .head2 (head2),
    .full  (fifo_full_unused),
    .empty (empty),
    .count (cnt),
    .ovf   (fifo_ovf)
  );
  // In REQ the head is the word on the bus, so a back-to-back load takes the entry behind it.
  always_comb begin
    pop = (state == REQ) & fm_wr_ack;
    load = (state == IDLE) ? (~empty & fm_cycle_en) : (pop & fm_cycle_en & (cnt > CW'(1)));
    state_nxt = load ? REQ : (pop ? IDLE : state);
    load_word = (state == REQ) ? head2 : head;
    base = (state == REQ) ? inc : nxt_off;
    lbank = (load_word[FW-1] & ~frame_alt_frz) ? ~bank : bank;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bank <= 1'b0;
      nxt_off <= '0;
      fm_wr_adrs <= '0;
      fm_wr_d <= '0;
    end else begin
      state <= state_nxt;
      if (pop) nxt_off <= inc;
      if (load) begin
        bank <= lbank;
        fm_wr_adrs <= {lbank, load_word[FW-1] ? OW'(0) : base};
        fm_wr_d <= load_word[FW-2:0];
      end
    end
endmodule
